elevator_scheduler: RTL and testbench

//  Collective (SCAN) controller for a 4-floor elevator car. Latches one-cycle hall/car request

---
 rtl/elevator_pkg.sv | 29 ++
 rtl/elev_timer.sv | 28 ++
 rtl/elevator_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_elevator_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and constants for the 4-floor collective elevator controller.
package elevator_pkg;

  localparam int unsigned NFLOORS       = 4;
  localparam int unsigned REQ_CAR       = 4;
  localparam int unsigned REQ_FLOOR_MSB = 3;
  localparam int unsigned REQ_FLOOR_LSB = 1;
  localparam int unsigned REQ_DOWN      = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE_UP,
    ST_MOVE_DN,
    ST_DOOR
  } state_e;

  typedef logic [NFLOORS-1:0] lamp_t;

  // Floors strictly above f.
  function automatic lamp_t above_mask(input logic [1:0] f);
    return (lamp_t'('1) << f) << 1;
  endfunction

  // Floors strictly below f.
  function automatic lamp_t below_mask(input logic [1:0] f);
    return ~(lamp_t'('1) << f);
  endfunction

endpackage

// File: rtl/elev_timer.sv
// Down-counting phase timer shared by the move and door phases; load wins over count.
module elev_timer #(
  parameter int unsigned TW = 28
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  input  logic          count_i,
  output logic          done_o
);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (count_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  // Asserted during the last cycle of a loaded interval.
  always_comb done_o = (cnt_q <= TW'(1));

endmodule

// File: rtl/elevator_scheduler.sv
// Collective (SCAN) controller for a 4-floor car: request latches, floor/direction
// tracking and IDLE/MOVE/DOOR sequencing driven by a shared phase timer.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned MOVE_CYCLES = 100_000_000,
  parameter int unsigned DOOR_CYCLES = 200_000_000,
  parameter int unsigned TW          = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [4:0] req_code,
  output logic [1:0] cur_floor,
  output logic       dir_up,
  output logic       moving,
  output logic       door_open,
  output logic [3:0] up_lamp,
  output logic [3:0] dn_lamp,
  output logic [3:0] car_lamp
);

  state_e        state_q, state_d;
  logic [1:0]    floor_q, floor_d;
  logic          dir_q, dir_d;
  lamp_t         up_q, up_d, dn_q, dn_d, car_q, car_d;

  logic          req_car, req_dn, req_ok, door_hit, latch_ok;
  logic [2:0]    req_fl;
  logic [1:0]    req_idx;
  lamp_t         req_onehot, set_up, set_dn, set_car;
  lamp_t         clr_up, clr_dn, clr_car, all_req, eval_onehot;

  logic [1:0]    eval_floor;
  logic          ah_up, ah_dn, here, ahead_dir, behind, dir_hall, opp_hall, stop;
  logic          enter_door;
  logic          tmr_load, tmr_count, tmr_done;
  logic [TW-1:0] tmr_val;

  elev_timer #(.TW(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .count_i    (tmr_count),
    .done_o     (tmr_done)
  );

  always_comb begin
    req_car  = req_code[REQ_CAR];
    req_dn   = req_code[REQ_DOWN];
    req_fl   = req_code[REQ_FLOOR_MSB:REQ_FLOOR_LSB];
    req_idx  = req_fl[1:0] - 2'd1;
    req_ok   = req_valid && (req_fl >= 3'd1) && (req_fl <= 3'd4)
               && !(req_car && req_dn)
               && !(!req_car && !req_dn && (req_fl == 3'd4))
               && !(!req_car && req_dn && (req_fl == 3'd1));
    // A call for the floor whose door is open is answered by holding the door.
    door_hit = req_ok && (state_q == ST_DOOR) && (req_idx == floor_q);
    latch_ok = req_ok && !door_hit;
    req_onehot = lamp_t'(1) << req_idx;
    set_car  = (latch_ok && req_car)            ? req_onehot : '0;
    set_up   = (latch_ok && !req_car && !req_dn) ? req_onehot : '0;
    set_dn   = (latch_ok && !req_car && req_dn)  ? req_onehot : '0;
  end

  // Floor being decided on: the arriving floor while moving, else the current one.
  always_comb begin
    eval_floor = floor_q;
    if ((state_q == ST_MOVE_UP) && (floor_q != 2'd3)) begin
      eval_floor = floor_q + 2'd1;
    end else if ((state_q == ST_MOVE_DN) && (floor_q != 2'd0)) begin
      eval_floor = floor_q - 2'd1;
    end
    eval_onehot = lamp_t'(1) << eval_floor;
    all_req   = up_q | dn_q | car_q;
    ah_up     = |(all_req & above_mask(eval_floor));
    ah_dn     = |(all_req & below_mask(eval_floor));
    here      = car_q[eval_floor] | up_q[eval_floor] | dn_q[eval_floor];
    ahead_dir = dir_q ? ah_up : ah_dn;
    behind    = dir_q ? ah_dn : ah_up;
    dir_hall  = dir_q ? up_q[eval_floor] : dn_q[eval_floor];
    opp_hall  = dir_q ? dn_q[eval_floor] : up_q[eval_floor];
    stop      = car_q[eval_floor] | dir_hall | (opp_hall & ~ahead_dir);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      floor_q <= '0;
      dir_q   <= 1'b1;
      up_q    <= '0;
      dn_q    <= '0;
      car_q   <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      car_q   <= car_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_d      = dir_q;
    tmr_load   = 1'b0;
    tmr_count  = 1'b0;
    tmr_val    = TW'(MOVE_CYCLES);
    enter_door = 1'b0;
    clr_up     = '0;
    clr_dn     = '0;
    clr_car    = '0;
    case (state_q)
      ST_IDLE: begin
        if (here) begin
          enter_door = 1'b1;
        end else if (ah_up && (dir_q || !ah_dn)) begin
          state_d  = ST_MOVE_UP;
          dir_d    = 1'b1;
          tmr_load = 1'b1;
        end else if (ah_dn) begin
          state_d  = ST_MOVE_DN;
          dir_d    = 1'b0;
          tmr_load = 1'b1;
        end
      end
      ST_MOVE_UP, ST_MOVE_DN: begin
        tmr_count = 1'b1;
        if (tmr_done) begin
          floor_d = eval_floor;
          if (stop) enter_door = 1'b1;
          else      tmr_load   = 1'b1;
        end
      end
      ST_DOOR: begin
        tmr_count = 1'b1;
        if (door_hit) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(DOOR_CYCLES);
        end else if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Door entry is shared by IDLE and MOVE; an answered opposite-direction hall call
    // also turns the car around, as does work remaining only behind it.
    if (enter_door) begin
      state_d  = ST_DOOR;
      tmr_load = 1'b1;
      tmr_val  = TW'(DOOR_CYCLES);
      clr_car  = eval_onehot;
      if (ahead_dir) begin
        if (dir_q) clr_up = eval_onehot;
        else       clr_dn = eval_onehot;
      end else begin
        clr_up = eval_onehot;
        clr_dn = eval_onehot;
        if (behind || opp_hall) dir_d = ~dir_q;
      end
    end
    up_d  = (up_q  & ~clr_up)  | set_up;
    dn_d  = (dn_q  & ~clr_dn)  | set_dn;
    car_d = (car_q & ~clr_car) | set_car;
  end

  always_comb begin
    cur_floor = floor_q;
    dir_up    = dir_q;
    moving    = (state_q == ST_MOVE_UP) || (state_q == ST_MOVE_DN);
    door_open = (state_q == ST_DOOR);
    up_lamp   = up_q;
    dn_lamp   = dn_q;
    car_lamp  = car_q;
  end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with short move/door intervals.
module tb_elevator_scheduler;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [4:0] req_code;
  logic [1:0] cur_floor;
  logic       dir_up, moving, door_open;
  logic [3:0] up_lamp, dn_lamp, car_lamp;

  int          checks;
  int          errors;
  logic [16:0] e;

  elevator_scheduler #(
    .MOVE_CYCLES (4),
    .DOOR_CYCLES (3),
    .TW          (28)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_code  (req_code),
    .cur_floor (cur_floor),
    .dir_up    (dir_up),
    .moving    (moving),
    .door_open (door_open),
    .up_lamp   (up_lamp),
    .dn_lamp   (dn_lamp),
    .car_lamp  (car_lamp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Packed view {floor, dir, moving, door, up, dn, car}.
  function automatic logic [16:0] outs();
    return {cur_floor, dir_up, moving, door_open, up_lamp, dn_lamp, car_lamp};
  endfunction

  function automatic logic [16:0] ev(input logic [1:0] f, input logic d, input logic m,
                                     input logic o, input logic [3:0] u,
                                     input logic [3:0] dn, input logic [3:0] c);
    return {f, d, m, o, u, dn, c};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [4:0] c);
    req_code  = c;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    req_code  = '0;
  endtask

  task automatic apply_reset();
    req_valid = 1'b0;
    req_code  = '0;
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 1'b0;
    req_code  = '0;
    rst = 1'b1;
    step();
    e = ev(2'd0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0); checks++;
    if (outs() !== e) begin errors++; $display("FAIL reset_held: got %b expected %b", outs(), e); end
    rst = 1'b0;
    step();
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL reset_release: got %b expected %b", outs(), e); end
  endtask

  task automatic test_car_call();
    apply_reset();
    send(5'b1_011_0);
    e = ev(2'd0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'b0100); checks++;
    if (outs() !== e) begin errors++; $display("FAIL car_latch: got %b expected %b", outs(), e); end
    step();
    e = ev(2'd0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'b0100); checks++;
    if (outs() !== e) begin errors++; $display("FAIL car_move_start: got %b expected %b", outs(), e); end
    steps(4);
    e = ev(2'd1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'b0100); checks++;
    if (outs() !== e) begin errors++; $display("FAIL car_floor1: got %b expected %b", outs(), e); end
    steps(4);
    e = ev(2'd2, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0); checks++;
    if (outs() !== e) begin errors++; $display("FAIL car_door: got %b expected %b", outs(), e); end
    steps(2);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL car_door_hold: got %b expected %b", outs(), e); end
    step();
    e = ev(2'd2, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0); checks++;
    if (outs() !== e) begin errors++; $display("FAIL car_idle: got %b expected %b", outs(), e); end
  endtask

  task automatic test_collective();
    apply_reset();
    send(5'b0_100_1);
    send(5'b0_010_0);
    e = ev(2'd0, 1'b1, 1'b1, 1'b0, 4'b0010, 4'b1000, 4'h0); checks++;
    if (outs() !== e) begin errors++; $display("FAIL coll_latch: got %b expected %b", outs(), e); end
    steps(4);
    e = ev(2'd1, 1'b1, 1'b0, 1'b1, 4'h0, 4'b1000, 4'h0); checks++;
    if (outs() !== e) begin errors++; $display("FAIL coll_stop2f: got %b expected %b", outs(), e); end
    steps(3);
    e = ev(2'd1, 1'b1, 1'b0, 1'b0, 4'h0, 4'b1000, 4'h0); checks++;
    if (outs() !== e) begin errors++; $display("FAIL coll_idle2f: got %b expected %b", outs(), e); end
    steps(5);
    e = ev(2'd2, 1'b1, 1'b1, 1'b0, 4'h0, 4'b1000, 4'h0); checks++;
    if (outs() !== e) begin errors++; $display("FAIL coll_pass3f: got %b expected %b", outs(), e); end
    steps(4);
    e = ev(2'd3, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0); checks++;
    if (outs() !== e) begin errors++; $display("FAIL coll_door4f: got %b expected %b", outs(), e); end
    steps(3);
    e = ev(2'd3, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0); checks++;
    if (outs() !== e) begin errors++; $display("FAIL coll_idle4f: got %b expected %b", outs(), e); end
  endtask

  task automatic test_pass_by();
    apply_reset();
    send(5'b1_011_0);
    send(5'b0_010_1);
    e = ev(2'd0, 1'b1, 1'b1, 1'b0, 4'h0, 4'b0010, 4'b0100); checks++;
    if (outs() !== e) begin errors++; $display("FAIL pass_latch: got %b expected %b", outs(), e); end
    steps(4);
    e = ev(2'd1, 1'b1, 1'b1, 1'b0, 4'h0, 4'b0010, 4'b0100); checks++;
    if (outs() !== e) begin errors++; $display("FAIL pass_no_stop: got %b expected %b", outs(), e); end
    steps(4);
    e = ev(2'd2, 1'b0, 1'b0, 1'b1, 4'h0, 4'b0010, 4'h0); checks++;
    if (outs() !== e) begin errors++; $display("FAIL pass_door3f: got %b expected %b", outs(), e); end
    steps(4);
    e = ev(2'd2, 1'b0, 1'b1, 1'b0, 4'h0, 4'b0010, 4'h0); checks++;
    if (outs() !== e) begin errors++; $display("FAIL pass_move_dn: got %b expected %b", outs(), e); end
    steps(4);
    e = ev(2'd1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0); checks++;
    if (outs() !== e) begin errors++; $display("FAIL pass_door2f: got %b expected %b", outs(), e); end
    steps(3);
    e = ev(2'd1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0); checks++;
    if (outs() !== e) begin errors++; $display("FAIL pass_idle2f: got %b expected %b", outs(), e); end
  endtask

  task automatic test_invalid();
    logic [4:0] codes [5];
    codes[0] = 5'b0_100_0;
    codes[1] = 5'b0_001_1;
    codes[2] = 5'b0_000_0;
    codes[3] = 5'b1_010_1;
    codes[4] = 5'b0_101_0;
    apply_reset();
    e = ev(2'd0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      send(codes[i]);
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL invalid_code_%0d (%b): got %b expected %b", i, codes[i], outs(), e);
      end
    end
    steps(2);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL invalid_stay_idle: got %b expected %b", outs(), e); end
  endtask

  task automatic test_door_restart();
    apply_reset();
    send(5'b1_010_0);
    steps(5);
    e = ev(2'd1, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0); checks++;
    if (outs() !== e) begin errors++; $display("FAIL dr_door: got %b expected %b", outs(), e); end
    step();
    send(5'b1_010_0);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL dr_not_latched: got %b expected %b", outs(), e); end
    steps(2);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL dr_hold: got %b expected %b", outs(), e); end
    step();
    e = ev(2'd1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0); checks++;
    if (outs() !== e) begin errors++; $display("FAIL dr_close: got %b expected %b", outs(), e); end
    step();
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL dr_stay_idle: got %b expected %b", outs(), e); end
  endtask

  task automatic test_reset_mid_move();
    apply_reset();
    send(5'b1_100_0);
    send(5'b0_011_1);
    steps(4);
    e = ev(2'd1, 1'b1, 1'b1, 1'b0, 4'h0, 4'b0100, 4'b1000); checks++;
    if (outs() !== e) begin errors++; $display("FAIL rm_pre: got %b expected %b", outs(), e); end
    rst = 1'b1;
    #1;
    e = ev(2'd0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0); checks++;
    if (outs() !== e) begin errors++; $display("FAIL rm_async: got %b expected %b", outs(), e); end
    step();
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL rm_held: got %b expected %b", outs(), e); end
    rst = 1'b0;
    steps(3);
    checks++;
    if (outs() !== e) begin errors++; $display("FAIL rm_discard: got %b expected %b", outs(), e); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_code  = '0;
    test_reset();
    test_car_call();
    test_collective();
    test_pass_by();
    test_invalid();
    test_door_restart();
    test_reset_mid_move();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
